microwave_timer: RTL and testbench

//   Cook-time register and 1 s countdown feeding microwave_fsm; consumes its mode output.

---
 rtl/microwave_timer.sv | 119 +++++++++++
 tb/tb_microwave_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// microwave_timer: cook-time register with a 1 s countdown.
// The time is adjusted in steps while the oven is in SET and counts down once per
// second while it is in RUN. The mode input comes from microwave_fsm, which reads
// run_time back to enable start and to detect the end of cooking.
// The remaining time is also presented as registered MM:SS BCD digits for the display.
module microwave_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int STEP_SEC = 30,
  parameter int MAX_SEC  = 5999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mode,
  input  logic        btnU,
  input  logic        btnD,
  output logic [13:0] run_time,
  output logic        done,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_ones
);

  typedef enum logic [2:0] {
    MODE_IDLE   = 3'd0,
    MODE_SET    = 3'd1,
    MODE_RUN    = 3'd2,
    MODE_STOP   = 3'd3,
    MODE_FINISH = 3'd4
  } mode_e;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [14:0]   MAX15      = 15'(MAX_SEC);
  localparam logic [14:0]   STEP15     = 15'(STEP_SEC);

  logic [PW-1:0] presc;
  logic          tick;
  logic          in_run;
  logic [14:0]   rt_ext;
  logic [14:0]   sum_up;
  logic [14:0]   sum_dn;
  logic [13:0]   rt_next;
  logic          done_next;
  logic [13:0]   mins;
  logic [13:0]   secs;

  assign in_run = (mode == MODE_RUN);
  assign tick   = in_run && (presc == PRESC_LAST);

  // Prescaler: counts only in RUN; any other mode discards the partial second.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    presc <= '0;
    else if (!in_run) presc <= '0;
    else if (tick)   presc <= '0;
    else             presc <= presc + PW'(1);
  end

  // Up and down steps are formed one bit wider so the clamps see true overflow.
  assign rt_ext = {1'b0, run_time};
  assign sum_up = rt_ext + STEP15;
  assign sum_dn = rt_ext - STEP15;

  // Next remaining time and end-of-countdown pulse, governed by the current mode.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rt_next   = run_time;
    done_next = 1'b0;
    case (mode)
      MODE_IDLE: rt_next = '0;
      MODE_SET: begin
        if (btnU && !btnD)
          rt_next = (sum_up > MAX15) ? MAX15[13:0] : sum_up[13:0];
        else if (btnD && !btnU)
          rt_next = (rt_ext < STEP15) ? '0 : sum_dn[13:0];
      end
      MODE_RUN: begin
        if (tick && (run_time != '0)) begin
          rt_next   = run_time - 14'd1;
          done_next = (run_time == 14'd1);
        end
      end
      default: ;  // STOP, FINISH and illegal codes hold the time
    endcase
  end

  // Remaining-time and done registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_time <= '0;
      done     <= 1'b0;
    end else begin
      run_time <= rt_next;
      done     <= done_next;
    end
  end

  // Minutes/seconds split of the current time; the digit registers add one cycle.
  assign mins = run_time / 14'd60;
  assign secs = run_time % 14'd60;

  // BCD digit registers for the display stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else begin
      min_tens <= 4'(mins / 14'd10);
      min_ones <= 4'(mins % 14'd10);
      sec_tens <= 4'(secs / 14'd10);
      sec_ones <= 4'(secs % 14'd10);
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed test of microwave_timer with a 10-cycle second.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_microwave_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode;
  logic        btnU;
  logic        btnD;
  logic [13:0] run_time;
  logic        done;
  logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] IDLE = 3'd0, SET = 3'd1, RUN = 3'd2, STOP = 3'd3, FINISH = 3'd4;

  microwave_timer #(.CLK_HZ(10), .STEP_SEC(30), .MAX_SEC(5999)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .btnU     (btnU),
    .btnD     (btnD),
    .run_time (run_time),
    .done     (done),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] digits();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_u();
    btnU = 1'b1; step(); btnU = 1'b0; step();
  endtask

  task automatic pulse_d();
    btnD = 1'b1; step(); btnD = 1'b0; step();
  endtask

  initial begin
    reset_n = 1'b0; mode = IDLE; btnU = 1'b0; btnD = 1'b0;
    #3;
    check("reset run_time", run_time, 0);
    check("reset done", done, 0);
    check("reset digits", digits(), 16'h0000);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: IDLE ignores buttons
    pulse_u();
    check("idle btnU run_time", run_time, 0);
    check("idle digits", digits(), 16'h0000);

    // 2: SET steps and one-cycle digit latency
    mode = SET;
    pulse_u(); pulse_u();
    btnU = 1'b1; step(); btnU = 1'b0;
    check("set 3x up", run_time, 90);
    check("digits lag one cycle", digits(), 16'h0100);
    step();
    check("digits 01:30", digits(), 16'h0130);
    btnD = 1'b1; step(); btnD = 1'b0;
    check("set down to 60", run_time, 60);
    step();
    check("digits 01:00", digits(), 16'h0100);

    // 3: saturation, underflow clamp, simultaneous buttons, illegal modes
    repeat (250) pulse_u();
    check("saturate 5999", run_time, 5999);
    check("digits 99:59", digits(), 16'h9959);
    btnD = 1'b1; step(); btnD = 1'b0;
    check("down from max", run_time, 5969);
    step();
    check("digits 99:29", digits(), 16'h9929);
    repeat (249) pulse_d();
    check("clamp at 0", run_time, 0);
    check("digits after clamp", digits(), 16'h0000);
    pulse_u();
    check("up to 30", run_time, 30);
    btnU = 1'b1; btnD = 1'b1; step(); btnU = 1'b0; btnD = 1'b0;
    check("both buttons hold", run_time, 30);
    mode = 3'd5; pulse_u();
    check("illegal 5 hold", run_time, 30);
    mode = 3'd7; pulse_d();
    check("illegal 7 hold", run_time, 30);
    check("illegal done", done, 0);
    mode = IDLE; step();
    check("idle clears", run_time, 0);

    // 4: full countdown from 30 s
    mode = SET; pulse_u();
    check("preload 30", run_time, 30);
    begin
      int n_done = 0;
      mode = RUN;
      for (int k = 1; k <= 300; k++) begin
        step();
        check($sformatf("run rt c%0d", k), run_time, 30 - k / 10);
        check($sformatf("run done c%0d", k), done, (k == 300) ? 1 : 0);
        if (done) n_done++;
      end
      for (int k = 0; k < 20; k++) begin
        step();
        if (done) n_done++;
      end
      check("run at 0 holds", run_time, 0);
      check("one done pulse", n_done, 1);
    end
    mode = FINISH; step();
    check("finish holds 0", run_time, 0);

    // 5: pause and resume discard the partial second
    mode = SET; pulse_u();
    mode = RUN;
    for (int k = 1; k <= 15; k++) begin
      btnU = (k == 3);
      step();
    end
    btnU = 1'b0;
    check("run 15 cycles", run_time, 29);
    mode = STOP;
    for (int k = 0; k < 50; k++) begin
      btnU = k[0];
      step();
    end
    btnU = 1'b0;
    check("stop holds 29", run_time, 29);
    mode = RUN;
    repeat (9) step();
    check("resume 9 cycles", run_time, 29);
    step();
    check("resume 10 cycles", run_time, 28);

    // 6: asynchronous reset during a countdown
    mode = IDLE; step();
    check("idle before 60", run_time, 0);
    mode = SET; pulse_u(); pulse_u();
    check("preload 60", run_time, 60);
    mode = RUN;
    repeat (150) step();
    check("run to 45", run_time, 45);
    repeat (4) step();
    check("digits 00:45", digits(), 16'h0045);
    reset_n = 1'b0;
    #1;
    check("async rst run_time", run_time, 0);
    check("async rst digits", digits(), 16'h0000);
    check("async rst done", done, 0);
    step();
    mode = SET;
    reset_n = 1'b1;
    step();
    pulse_u();
    check("post reset 30", run_time, 30);
    mode = RUN;
    repeat (9) step();
    check("post reset 9 cycles", run_time, 30);
    step();
    check("post reset 10 cycles", run_time, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
